// File: rtl/dma_axis_pkg.sv
// Shared AXIS definitions for the DMA rx path: arbiter FSM states and the TUSER field layout.
package dma_axis_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PASS = 1'b1
  } arb_state_e;

  localparam int TUSER_LEN_LSB = 0;
  localparam int TUSER_LEN_W   = 16;
  localparam int TUSER_SRC_LSB = 16;
  localparam int TUSER_SRC_W   = 8;
  localparam int TUSER_DST_LSB = 24;
  localparam int TUSER_DST_W   = 8;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry FIFO skid buffer: one cycle in-to-out; in_rdy while any entry is free,
// head entry held stable while out_rdy is low.
module axis_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       cnt_q;
  logic             push;
  logic             pop;

  assign in_rdy  = (cnt_q != 2'd2);
  assign out_vld = (cnt_q != 2'd0);
  assign out_dat = mem_q[rd_ptr_q];
  assign push    = in_vld && in_rdy;
  assign pop     = out_vld && out_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_dat;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/dma_rx_arbiter.sv
// Round-robin packet arbiter merging NUM_PORTS MAC rx AXIS streams into one DMA stream.
// One cycle input-to-output through a 2-entry skid buffer; the granted port sees the buffer's ready.
module dma_rx_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 128
) (
  input  logic                            axi_clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic [NUM_PORTS*USER_WIDTH-1:0]   s_axis_tuser,
  input  logic [NUM_PORTS-1:0]              s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]              s_axis_tlast,
  output logic [NUM_PORTS-1:0]              s_axis_tready,
  output logic [DATA_WIDTH-1:0]             m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]           m_axis_tstrb,
  output logic [USER_WIDTH-1:0]             m_axis_tuser,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  output logic [NUM_PORTS*32-1:0]           pkt_cnt
);

  import dma_axis_pkg::*;

  localparam int SEL_W  = $clog2(NUM_PORTS);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int PAY_W  = 1 + USER_WIDTH + STRB_W + DATA_WIDTH;

  logic [DATA_WIDTH-1:0] tdata_arr [NUM_PORTS];
  logic [STRB_W-1:0]     tstrb_arr [NUM_PORTS];
  logic [USER_WIDTH-1:0] tuser_arr [NUM_PORTS];

  arb_state_e       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0] pe_idx, gnt_idx;
  logic [NUM_PORTS-1:0] rot_vld;
  logic [NUM_PORTS-1:0] cnt_inc;

  logic              tvalid_sel;
  logic              tlast_sel;
  logic [USER_WIDTH-1:0] user_mod;
  logic              skid_in_vld;
  logic              skid_in_rdy;
  logic [PAY_W-1:0]  skid_in_dat;
  logic [PAY_W-1:0]  skid_out_dat;

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      tdata_arr[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
      tstrb_arr[i] = s_axis_tstrb[i*STRB_W +: STRB_W];
      tuser_arr[i] = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
    end
  end

  // Rotate requests so rr_ptr sits at bit 0, pick the lowest, then rotate the index back.
  always_comb begin
    rot_vld = '0;
    pe_idx  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      rot_vld[i] = s_axis_tvalid[SEL_W'((i + int'(rr_ptr_q)) % NUM_PORTS)];
    end
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (rot_vld[i]) pe_idx = SEL_W'(i);
    end
    gnt_idx = SEL_W'((int'(pe_idx) + int'(rr_ptr_q)) % NUM_PORTS);
  end

  assign tvalid_sel = s_axis_tvalid[sel_q];
  assign tlast_sel  = s_axis_tlast[sel_q];

  always_comb begin
    user_mod = tuser_arr[sel_q];
    user_mod[TUSER_SRC_LSB +: TUSER_SRC_W] = TUSER_SRC_W'(1) << sel_q;
  end

  assign skid_in_dat = {tlast_sel, user_mod, tstrb_arr[sel_q], tdata_arr[sel_q]};

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    rr_ptr_d      = rr_ptr_q;
    s_axis_tready = '0;
    skid_in_vld   = 1'b0;
    cnt_inc       = '0;
    case (state_q)
      ST_IDLE: begin
        if (|s_axis_tvalid) begin
          sel_d   = gnt_idx;
          state_d = ST_PASS;
        end
      end
      ST_PASS: begin
        s_axis_tready[sel_q] = skid_in_rdy;
        skid_in_vld          = tvalid_sel;
        if (tvalid_sel && skid_in_rdy && tlast_sel) begin
          state_d        = ST_IDLE;
          rr_ptr_d       = SEL_W'((int'(sel_q) + 1) % NUM_PORTS);
          cnt_inc[sel_q] = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge axi_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  axis_skid_buf #(
    .WIDTH (PAY_W)
  ) u_skid (
    .clk     (axi_clk),
    .rst_n   (rst_n),
    .in_vld  (skid_in_vld),
    .in_rdy  (skid_in_rdy),
    .in_dat  (skid_in_dat),
    .out_vld (m_axis_tvalid),
    .out_rdy (m_axis_tready),
    .out_dat (skid_out_dat)
  );

  assign {m_axis_tlast, m_axis_tuser, m_axis_tstrb, m_axis_tdata} = skid_out_dat;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt
    logic [31:0] cnt_q;
    always_ff @(posedge axi_clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (cnt_inc[g]) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
    assign pkt_cnt[g*32 +: 32] = cnt_q;
  end

endmodule

// File: tb/tb_dma_rx_arbiter.sv
// Randomized bench for dma_rx_arbiter: packets per port are predicted by a round-robin packet model.
module tb_dma_rx_arbiter;

  localparam int NP = 4;
  localparam int DW = 64;
  localparam int SW = DW / 8;
  localparam int UW = 128;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  logic              axi_clk = 1'b0;
  logic              rst_n   = 1'b0;
  logic [NP*DW-1:0]  s_axis_tdata;
  logic [NP*SW-1:0]  s_axis_tstrb;
  logic [NP*UW-1:0]  s_axis_tuser;
  logic [NP-1:0]     s_axis_tvalid;
  logic [NP-1:0]     s_axis_tlast;
  logic [NP-1:0]     s_axis_tready;
  logic [DW-1:0]     m_axis_tdata;
  logic [SW-1:0]     m_axis_tstrb;
  logic [UW-1:0]     m_axis_tuser;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic              m_axis_tready;
  logic [NP*32-1:0]  pkt_cnt;

  always #5 axi_clk = ~axi_clk;

  dma_rx_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .USER_WIDTH(UW)) dut (
    .axi_clk       (axi_clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tstrb  (s_axis_tstrb),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tstrb  (m_axis_tstrb),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .pkt_cnt       (pkt_cnt)
  );

  int errors = 0;
  int checks = 0;

  beat_t port_q [NP][$];
  beat_t model_q[NP][$];
  beat_t rx_q[$];
  beat_t exp_q[$];
  int    exp_cnt[NP];
  logic [NP-1:0] port_en;

  logic          obs_vld;
  logic          obs_rdy;
  beat_t         obs_beat;
  logic [NP-1:0] obs_s_rdy;
  logic [NP-1:0] obs_acc;

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      beat_t b;
      b = '0;
      if (port_q[p].size() > 0) b = port_q[p][0];
      s_axis_tvalid[p]            = port_en[p] && (port_q[p].size() > 0);
      s_axis_tdata[p*DW +: DW]    = b.data;
      s_axis_tstrb[p*SW +: SW]    = b.strb;
      s_axis_tuser[p*UW +: UW]    = b.user;
      s_axis_tlast[p]             = b.last;
    end
  endtask

  // Samples both interfaces at the falling edge, then applies source-side pops after the rising edge.
  task automatic tick();
    @(negedge axi_clk);
    obs_acc       = s_axis_tvalid & s_axis_tready;
    obs_s_rdy     = s_axis_tready;
    obs_vld       = m_axis_tvalid;
    obs_rdy       = m_axis_tready;
    obs_beat.data = m_axis_tdata;
    obs_beat.strb = m_axis_tstrb;
    obs_beat.user = m_axis_tuser;
    obs_beat.last = m_axis_tlast;
    if (m_axis_tvalid && m_axis_tready) rx_q.push_back(obs_beat);
    @(posedge axi_clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (obs_acc[p]) void'(port_q[p].pop_front());
    end
    drive();
  endtask

  task automatic add_pkt(input int p, input int nb);
    logic [UW-1:0] u;
    u = {$urandom, $urandom, $urandom, $urandom};
    u[15:0] = 16'(nb * 8);
    for (int i = 0; i < nb; i++) begin
      beat_t b;
      b.data = {$urandom, $urandom};
      b.strb = 8'($urandom);
      b.user = u;
      b.last = (i == nb - 1);
      port_q[p].push_back(b);
      model_q[p].push_back(b);
    end
  endtask

  // Whole-packet round robin over the ports that still hold packets, starting from port 0.
  task automatic build_expected();
    int  rr;
    int  pick;
    bit  done;
    beat_t b;
    rr = 0;
    exp_q.delete();
    forever begin
      pick = -1;
      for (int k = 0; k < NP; k++) begin
        if (pick < 0 && model_q[(rr + k) % NP].size() > 0) pick = (rr + k) % NP;
      end
      if (pick < 0) break;
      done = 1'b0;
      while (!done) begin
        b = model_q[pick].pop_front();
        b.user[23:16] = 8'(1 << pick);
        exp_q.push_back(b);
        done = b.last;
      end
      exp_cnt[pick]++;
      rr = (pick + 1) % NP;
    end
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    m_axis_tready = 1'b1;
    port_en       = '1;
    for (int p = 0; p < NP; p++) begin
      port_q[p].delete();
      model_q[p].delete();
      exp_cnt[p] = 0;
    end
    rx_q.delete();
    exp_q.delete();
    drive();
    repeat (3) @(posedge axi_clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    add_pkt(1, 2);
    drive();
    repeat (2) @(posedge axi_clk);
    @(negedge axi_clk);
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
    checks++; if (s_axis_tready !== '0) begin errors++; $display("FAIL reset_tready: got %b want 0", s_axis_tready); end
    checks++; if (pkt_cnt !== '0) begin errors++; $display("FAIL reset_pkt_cnt: got %h want 0", pkt_cnt); end
    checks++; if (m_axis_tdata !== '0) begin errors++; $display("FAIL reset_tdata: got %h want 0", m_axis_tdata); end
    checks++; if (m_axis_tstrb !== '0) begin errors++; $display("FAIL reset_tstrb: got %h want 0", m_axis_tstrb); end
    checks++; if (m_axis_tuser !== '0) begin errors++; $display("FAIL reset_tuser: got %h want 0", m_axis_tuser); end
  endtask

  task automatic test_single();
    int n;
    bit seen;
    do_reset();
    add_pkt(2, 3);
    build_expected();
    drive();
    n = 0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (obs_vld) seen = 1'b1;
      else n++;
    end
    checks++; if (n !== 2) begin errors++; $display("FAIL single_latency: got %0d cycles want 2", n); end
    for (int c = 0; c < 40 && rx_q.size() < 3; c++) tick();
    checks++; if (rx_q.size() !== 3) begin errors++; $display("FAIL single_count: got %0d want 3", rx_q.size()); end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL single_beat%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
    end
    if (rx_q.size() > 0) begin
      checks++; if (rx_q[0].user[23:16] !== 8'h04) begin errors++; $display("FAIL single_src: got %h want 04", rx_q[0].user[23:16]); end
      checks++; if (rx_q[0].user[15:0] !== 16'd24) begin errors++; $display("FAIL single_len: got %0d want 24", rx_q[0].user[15:0]); end
    end
    checks++; if (pkt_cnt[95:64] !== 32'd1) begin errors++; $display("FAIL single_cnt2: got %0d want 1", pkt_cnt[95:64]); end
  endtask

  task automatic test_fairness();
    do_reset();
    for (int p = 0; p < NP; p++) begin
      add_pkt(p, 1);
      add_pkt(p, 1);
    end
    build_expected();
    drive();
    for (int c = 0; c < 100 && rx_q.size() < 8; c++) tick();
    checks++; if (rx_q.size() !== 8) begin errors++; $display("FAIL fair_count: got %0d want 8", rx_q.size()); end
    for (int i = 0; i < rx_q.size() && i < 8; i++) begin
      checks++; if (rx_q[i].user[23:16] !== 8'(1 << (i % NP))) begin errors++; $display("FAIL fair_order%0d: got src %h want %h", i, rx_q[i].user[23:16], 8'(1 << (i % NP))); end
      checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL fair_beat%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    bit    prev_stall;
    beat_t prev_beat;
    int    stab_err;
    do_reset();
    add_pkt(0, 8);
    build_expected();
    drive();
    prev_stall = 1'b0;
    prev_beat  = '0;
    stab_err   = 0;
    for (int c = 0; c < 200 && rx_q.size() < 8; c++) begin
      m_axis_tready = (c % 3 == 0);
      tick();
      if (prev_stall && (!obs_vld || obs_beat !== prev_beat)) stab_err++;
      prev_stall = obs_vld && !obs_rdy;
      prev_beat  = obs_beat;
    end
    m_axis_tready = 1'b1;
    checks++; if (stab_err !== 0) begin errors++; $display("FAIL bp_stable: got %0d changes want 0", stab_err); end
    checks++; if (rx_q.size() !== 8) begin errors++; $display("FAIL bp_count: got %0d want 8", rx_q.size()); end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_beat%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_non_interleave();
    int acc1;
    int gap;
    bit p1_done;
    int rdy3_err;
    do_reset();
    add_pkt(1, 4);
    add_pkt(3, 2);
    build_expected();
    port_en = 4'b0010;
    drive();
    acc1 = 0; gap = 0; p1_done = 1'b0; rdy3_err = 0;
    for (int c = 0; c < 200 && rx_q.size() < 6; c++) begin
      tick();
      if (!p1_done && obs_s_rdy[3]) rdy3_err++;
      acc1 += int'(obs_acc[1]);
      if (acc1 == 4) p1_done = 1'b1;
      if (acc1 >= 2 && gap < 5) begin
        port_en[1] = 1'b0;
        port_en[3] = 1'b1;
        gap++;
      end else if (gap >= 5) begin
        port_en[1] = 1'b1;
      end
      drive();
    end
    checks++; if (rdy3_err !== 0) begin errors++; $display("FAIL ni_ready3: got %0d cycles high want 0", rdy3_err); end
    checks++; if (rx_q.size() !== 6) begin errors++; $display("FAIL ni_count: got %0d want 6", rx_q.size()); end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL ni_beat%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
    end
    if (rx_q.size() > 4) begin
      checks++; if (rx_q[4].user[23:16] !== 8'h08) begin errors++; $display("FAIL ni_next_src: got %h want 08", rx_q[4].user[23:16]); end
    end
    checks++; if (pkt_cnt[63:32] !== 32'd1 || pkt_cnt[127:96] !== 32'd1) begin errors++; $display("FAIL ni_cnt: got %h want cnt1=1 cnt3=1", pkt_cnt); end
  endtask

  task automatic test_reset_mid();
    int acc0;
    do_reset();
    add_pkt(0, 4);
    drive();
    acc0 = 0;
    for (int c = 0; c < 50 && acc0 < 2; c++) begin
      tick();
      acc0 += int'(obs_acc[0]);
    end
    rst_n = 1'b0;
    #1;
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rmid_tvalid: got %b want 0", m_axis_tvalid); end
    checks++; if (s_axis_tready !== '0) begin errors++; $display("FAIL rmid_tready: got %b want 0", s_axis_tready); end
    for (int p = 0; p < NP; p++) begin
      port_q[p].delete();
      model_q[p].delete();
      exp_cnt[p] = 0;
    end
    drive();
    repeat (2) @(posedge axi_clk);
    #1;
    rst_n = 1'b1;
    rx_q.delete();
    checks++; if (pkt_cnt !== '0) begin errors++; $display("FAIL rmid_cnt_zero: got %h want 0", pkt_cnt); end
    add_pkt(0, 3);
    build_expected();
    drive();
    for (int c = 0; c < 50 && rx_q.size() < 3; c++) tick();
    checks++; if (rx_q.size() !== 3) begin errors++; $display("FAIL rmid_count: got %0d want 3", rx_q.size()); end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL rmid_beat%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
    end
    checks++; if (pkt_cnt[31:0] !== 32'd1) begin errors++; $display("FAIL rmid_cnt0: got %0d want 1", pkt_cnt[31:0]); end
  endtask

  task automatic test_wrap();
    do_reset();
    force dut.g_cnt[1].cnt_q = 32'hFFFF_FFFF;
    @(posedge axi_clk);
    #1;
    release dut.g_cnt[1].cnt_q;
    #1;
    checks++; if (pkt_cnt[63:32] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preload: got %h want ffffffff", pkt_cnt[63:32]); end
    add_pkt(1, 2);
    build_expected();
    drive();
    for (int c = 0; c < 50 && rx_q.size() < 2; c++) tick();
    checks++; if (rx_q.size() !== 2) begin errors++; $display("FAIL wrap_count: got %0d want 2", rx_q.size()); end
    checks++; if (pkt_cnt[63:32] !== 32'd0) begin errors++; $display("FAIL wrap_cnt1: got %h want 0", pkt_cnt[63:32]); end
  endtask

  task automatic test_random();
    bit    prev_stall;
    beat_t prev_beat;
    int    stab_err;
    for (int iter = 0; iter < 3; iter++) begin
      do_reset();
      for (int p = 0; p < NP; p++) begin
        int npk;
        npk = $urandom_range(0, 4);
        for (int k = 0; k < npk; k++) add_pkt(p, $urandom_range(1, 6));
      end
      build_expected();
      drive();
      prev_stall = 1'b0;
      prev_beat  = '0;
      stab_err   = 0;
      for (int c = 0; c < 3000 && rx_q.size() < exp_q.size(); c++) begin
        m_axis_tready = ($urandom_range(0, 3) != 0);
        tick();
        if (prev_stall && (!obs_vld || obs_beat !== prev_beat)) stab_err++;
        prev_stall = obs_vld && !obs_rdy;
        prev_beat  = obs_beat;
      end
      m_axis_tready = 1'b1;
      checks++; if (stab_err !== 0) begin errors++; $display("FAIL rand%0d_stable: got %0d changes want 0", iter, stab_err); end
      checks++; if (rx_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand%0d_count: got %0d want %0d", iter, rx_q.size(), exp_q.size()); end
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
        checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_beat%0d: got %h want %h", iter, i, rx_q[i], exp_q[i]); end
      end
      for (int p = 0; p < NP; p++) begin
        checks++; if (pkt_cnt[p*32 +: 32] !== 32'(exp_cnt[p])) begin errors++; $display("FAIL rand%0d_cnt%0d: got %0d want %0d", iter, p, pkt_cnt[p*32 +: 32], exp_cnt[p]); end
      end
    end
  endtask

  initial begin
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    s_axis_tdata  = '0;
    s_axis_tstrb  = '0;
    s_axis_tuser  = '0;
    m_axis_tready = 1'b1;
    port_en       = '1;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_non_interleave();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dma_rx_arbiter.md
DMA_RX_ARBITER -- requirements
Module: dma_rx_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 4, number of MAC rx AXIS input streams (2..8).
REQ-002 Parameter DATA_WIDTH, default 64, TDATA width; TSTRB width is DATA_WIDTH/8.
REQ-003 Parameter USER_WIDTH, default 128, TUSER width.
REQ-004 Clocking and reset SHALL be: one clock, axi_clk; reset rst_n is asynchronous and active-low.
REQ-005 axi_clk  in  1  sole clock; all state on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 s_axis_tdata  in  NUM_PORTS*DATA_WIDTH  per-port data, port i at slice i.
REQ-008 s_axis_tstrb  in  NUM_PORTS*DATA_WIDTH/8  per-port byte strobes.
REQ-009 s_axis_tuser  in  NUM_PORTS*USER_WIDTH  per-port sideband; bits [15:0] are the byte length.
REQ-010 s_axis_tvalid / s_axis_tlast  in  NUM_PORTS each  per-port valid and last.
REQ-011 s_axis_tready  out  NUM_PORTS  per-port ready.
REQ-012 m_axis_tdata/tstrb/tuser/tvalid/tlast  out  DATA_WIDTH/DATA_WIDTH/8/USER_WIDTH/1/1  merged stream to the DMA engine MAC-rx port.
REQ-013 m_axis_tready  in  1  downstream ready.
REQ-014 pkt_cnt  out  NUM_PORTS*32  per-port forwarded-packet counters.

Function
REQ-015 FSM states: IDLE and PASS.
REQ-016 In IDLE, the block SHALL grant the lowest-indexed valid port at or after rr_ptr, cyclically; it SHALL latch the grant as sel and enter PASS on the next edge.
REQ-017 In IDLE, all s_axis_tready SHALL be 0.
REQ-018 In PASS, s_axis_tready[sel] SHALL equal the skid buffer's input ready; every other port's ready SHALL be 0.
REQ-019 On acceptance of a beat with tlast=1 in PASS, the block SHALL return to IDLE, set rr_ptr=(sel+1) mod NUM_PORTS, and increment pkt_cnt[sel].
REQ-020 Packets SHALL never interleave; at least one IDLE cycle separates consecutive grants.
REQ-021 Forwarded tdata, tstrb and tlast SHALL be unmodified.
REQ-022 Forwarded tuser SHALL equal input tuser with bits [23:16] replaced by a one-hot of sel (bit 16+sel).
REQ-023 Latency SHALL be one cycle, input acceptance to m_axis_tvalid; in steady state throughput is one beat per cycle within a packet.
REQ-024 The skid buffer SHALL hold 2 entries: input ready is 1 when at least one entry is free; m_axis_tvalid is 1 when at least one entry is full; beats leave in FIFO order.
REQ-025 m_axis outputs SHALL hold stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-026 With no input valid, the FSM SHALL stay in IDLE and rr_ptr SHALL stay unchanged.
REQ-027 A port dropping tvalid mid-packet SHALL be waited on; the grant SHALL be kept until tlast, with no timeout.
REQ-028 pkt_cnt SHALL wrap from 0xFFFFFFFF to 0.
REQ-029 A tlast beat and a new request arriving in the same cycle SHALL be arbitrated in the following IDLE cycle using the updated rr_ptr.

Reset
REQ-030 While rst_n=0 the block SHALL hold: state=IDLE, rr_ptr=0, sel=0, both skid entries empty, m_axis_tvalid=0, all s_axis_tready=0, pkt_cnt=0.
REQ-031 Reset asserted mid-packet SHALL discard the partial packet immediately; after reset release, output SHALL resume on a packet boundary.
REQ-032 m_axis_tdata, m_axis_tstrb and m_axis_tuser SHALL reset to 0.

Structure
REQ-033 The FSM state enum and the TUSER field offsets (LEN [15:0], SRC [23:16], DST [31:24]) SHALL be defined in a shared package, dma_axis_pkg.
REQ-034 The 2-entry skid buffer SHALL be a sub-module named axis_skid_buf, parameterised by the total payload width.
REQ-035 Arbitration SHALL be a combinational rotate / priority-encode / unrotate, with no extra pipeline stage.

Verification
REQ-036 Single packet: port 2, 3 beats, tuser[15:0]=24, m_axis_tready=1 -> 3 output beats; first beat 2 cycles after tvalid rises; tuser[23:16]=0x04; pkt_cnt[2]=1.
REQ-037 Fairness: all 4 ports continuously valid with 1-beat packets, 8 grants -> order 0,1,2,3,0,1,2,3.
REQ-038 Backpressure: 8-beat packet on port 0, m_axis_tready toggled 1,0,0,1,... -> all 8 beats delivered in order, no duplicates, outputs stable while stalled.
REQ-039 Non-interleave: port 1 mid-packet drops tvalid for 5 cycles while port 3 is valid -> s_axis_tready[3]=0 until port 1's tlast is accepted; port 3 is granted next.
REQ-040 Reset mid-packet: rst_n=0 at beat 2 of 4 -> m_axis_tvalid=0 immediately; after release, a new port 0 packet is forwarded intact; pkt_cnt all 0 before it.
REQ-041 Counter wrap: pkt_cnt[1] forced to 0xFFFFFFFF, one packet sent -> pkt_cnt[1]=0.
